// File: rtl/activation_grad_unit.sv
// Backward activation stage: delta = g * f'(z), 3-stage valid/ready pipe with vector tagging.
// Optional saturation counter port sat_cnt_o is enabled by defining ACTIV_GRAD_SAT_CNT_EN.
module activation_grad_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4,
    parameter int VEC_LEN    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            activ_type_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] z_i,
    input  logic [DATA_WIDTH-1:0] y_i,
    input  logic [DATA_WIDTH-1:0] g_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] delta_o,
    output logic                  last_o,
    output logic                  done_o
`ifdef ACTIV_GRAD_SAT_CNT_EN
    ,
    output logic [15:0]           sat_cnt_o
`endif
);

    localparam int DW2 = 2 * DATA_WIDTH;
    localparam int PW  = 3 * DATA_WIDTH;
    localparam int CW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic signed [DW2-1:0] ONE      = DW2'(1) << FRAC_BITS;
    localparam logic        [CW-1:0]  LAST_CNT = CW'(VEC_LEN - 1);
    localparam logic signed [PW-1:0]  MAXV     = PW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0]  MINV     = ~MAXV;

    typedef enum logic [1:0] {
        RELU  = 2'd0,
        SIGM  = 2'd1,
        TANH  = 2'd2,
        IDENT = 2'd3
    } activ_e;

    logic [3:1] vld_pipe;
    logic       adv1, adv2, adv3, accept;

    logic [CW-1:0] cnt;
    activ_e        type_q, cur_type;

    logic signed [DW2-1:0]        z_ext, y_ext, d_next;
    logic signed [DW2-1:0]        d1;
    logic signed [DATA_WIDTH-1:0] g1;
    logic                         last1;
    logic signed [PW-1:0]         p2;
    logic                         last2;
    logic signed [PW-1:0]         g1_ext, d1_ext, sh;
    logic signed [DATA_WIDTH-1:0] sat_val;
    logic                         sat_hit;

    // Each stage moves when the one after it is empty or moving on.
    assign adv3       = vld_pipe[3] & out_ready_i;
    assign adv2       = vld_pipe[2] & (~vld_pipe[3] | adv3);
    assign adv1       = vld_pipe[1] & (~vld_pipe[2] | adv2);
    assign in_ready_o = ~vld_pipe[1] | adv1;
    assign accept     = in_valid_i & in_ready_o;

    assign out_valid_o = vld_pipe[3];
    assign done_o      = vld_pipe[3] & out_ready_i & last_o;

    // The first element of a vector uses the live type; the rest use the latched one.
    assign cur_type = (cnt == '0) ? activ_e'(activ_type_i) : type_q;

    assign z_ext = {{DATA_WIDTH{z_i[DATA_WIDTH-1]}}, z_i};
    assign y_ext = {{DATA_WIDTH{y_i[DATA_WIDTH-1]}}, y_i};

    always_comb begin
        d_next = ONE;
        case (cur_type)
            RELU:    d_next = (z_ext > 0) ? ONE : '0;
            SIGM:    d_next = (y_ext * (ONE - y_ext)) >>> FRAC_BITS;
            TANH:    d_next = ONE - ((y_ext * y_ext) >>> FRAC_BITS);
            IDENT:   d_next = ONE;
            default: d_next = ONE;
        endcase
    end

    assign g1_ext = {{DW2{g1[DATA_WIDTH-1]}}, g1};
    assign d1_ext = {{DATA_WIDTH{d1[DW2-1]}}, d1};
    assign sh     = p2 >>> FRAC_BITS;

    always_comb begin
        sat_val = DATA_WIDTH'(sh);
        sat_hit = 1'b0;
        if (sh > MAXV) begin
            sat_val = DATA_WIDTH'(MAXV);
            sat_hit = 1'b1;
        end else if (sh < MINV) begin
            sat_val = DATA_WIDTH'(MINV);
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            type_q <= RELU;
        end else if (accept) begin
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
            if (cnt == '0)
                type_q <= activ_e'(activ_type_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            d1       <= '0;
            g1       <= '0;
            last1    <= 1'b0;
            p2       <= '0;
            last2    <= 1'b0;
            delta_o  <= '0;
            last_o   <= 1'b0;
        end else begin
            if (in_ready_o) begin
                vld_pipe[1] <= in_valid_i;
                if (in_valid_i) begin
                    d1    <= d_next;
                    g1    <= g_i;
                    last1 <= (cnt == LAST_CNT);
                end
            end
            if (~vld_pipe[2] | adv2) begin
                vld_pipe[2] <= adv1;
                if (adv1) begin
                    p2    <= g1_ext * d1_ext;
                    last2 <= last1;
                end
            end
            if (~vld_pipe[3] | adv3) begin
                vld_pipe[3] <= adv2;
                if (adv2) begin
                    delta_o <= sat_val;
                    last_o  <= last2;
                end
            end
        end
    end

`ifdef ACTIV_GRAD_SAT_CNT_EN
    logic sat3;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sat3 <= 1'b0;
        else if ((~vld_pipe[3] | adv3) & adv2)
            sat3 <= sat_hit;
    end

    // A vector boundary restarts the count, keeping a saturation seen on that same transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            sat_cnt_o <= '0;
        else if (done_o)
            sat_cnt_o <= {15'd0, sat3};
        else if (adv3 && sat3 && sat_cnt_o != 16'hFFFF)
            sat_cnt_o <= sat_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_activation_grad_unit.sv
// Directed bench for activation_grad_unit (DATA_WIDTH=8, FRAC_BITS=4, VEC_LEN=4).
module tb_activation_grad_unit;

    localparam int DW = 8;
    localparam int FB = 4;
    localparam int VL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    activ_type;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] z_in, y_in, g_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] delta;
    logic          last;
    logic          done;
`ifdef ACTIV_GRAD_SAT_CNT_EN
    logic [15:0]   sat_cnt;
`endif

    always #5 clk = ~clk;

    activation_grad_unit #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .VEC_LEN(VL)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .activ_type_i(activ_type),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .z_i(z_in),
        .y_i(y_in),
        .g_i(g_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .delta_o(delta),
        .last_o(last),
        .done_o(done)
`ifdef ACTIV_GRAD_SAT_CNT_EN
        ,
        .sat_cnt_o(sat_cnt)
`endif
    );

    typedef struct {
        int   dv;
        logic lt;
        logic dn;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   occ = 0, max_occ = 0, stall_err = 0, stray_done = 0, not_ready_seen = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_delta = '0;
    logic          prev_last = 1'b0;
    int   ev[8];
    logic lv[8];

    // Transfer recorder plus stall-stability and occupancy tracking.
    always @(negedge clk) begin
        if (rst) begin
            occ        <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!out_valid || delta !== prev_delta || last !== prev_last))
                stall_err <= stall_err + 1;
            prev_stall <= out_valid && !out_ready;
            prev_delta <= delta;
            prev_last  <= last;
            if (out_valid && out_ready)
                q.push_back('{$signed(delta), last, done});
            else if (done)
                stray_done <= stray_done + 1;
            occ <= occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            if (occ > max_occ)
                max_occ <= occ;
            if (in_valid && !in_ready)
                not_ready_seen <= not_ready_seen + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] t, input int z, input int y, input int g);
        int n;
        activ_type = t;
        z_in       = z[DW-1:0];
        y_in       = y[DW-1:0];
        g_in       = g[DW-1:0];
        in_valid   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            chk("send_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input string tag, input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_count"}, q.size(), n);
    endtask

    task automatic check_out(input string tag, input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) begin
                chk({tag, "_missing"}, q.size(), 1);
                break;
            end
            r = q.pop_front();
            chk($sformatf("%s_delta%0d", tag, i), r.dv, ev[i]);
            chk($sformatf("%s_last%0d", tag, i), int'(r.lt), int'(lv[i]));
            chk($sformatf("%s_done%0d", tag, i), int'(r.dn), int'(lv[i]));
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        activ_type = 2'd0;
        z_in = '0; y_in = '0; g_in = '0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_delta", int'(delta), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // ReLU vector with latency probe
        send(2'd0, 5, 0, 20);
        chk("relu_lat1", int'(out_valid), 0);
        send(2'd0, -3, 0, 20);
        chk("relu_lat2", int'(out_valid), 0);
        send(2'd0, 0, 0, 20);
        chk("relu_lat3", int'(out_valid), 1);
        chk("relu_lat3_delta", $signed(delta), 20);
        send(2'd0, 1, 0, -7);
        wait_q("relu", 4);
        ev = '{20, 0, 0, -7, 0, 0, 0, 0};
        lv = '{0, 0, 0, 1, 0, 0, 0, 0};
        check_out("relu", 4);

        // Sigmoid: d = y*(16-y)>>>4
        send(2'd1, 0, 8, 32);
        send(2'd1, 0, 4, 64);
        send(2'd1, 0, 4, -1);
        send(2'd1, 0, 8, -32);
        wait_q("sigm", 4);
        ev = '{8, 12, -1, -8, 0, 0, 0, 0};
        check_out("sigm", 4);

        // Tanh, saturating on the last element
        send(2'd2, 0, 0, -40);
        send(2'd2, 0, 8, 16);
        send(2'd2, 0, 16, 10);
        send(2'd2, 0, -128, 16);
        wait_q("tanh", 4);
        ev = '{-40, 12, 0, -128, 0, 0, 0, 0};
        check_out("tanh", 4);
`ifdef ACTIV_GRAD_SAT_CNT_EN
        chk("sat_cnt", int'(sat_cnt), 1);
`endif

        // Identity, with z/y ignored
        send(2'd3, -50, 77, -128);
        send(2'd3, 3, -9, 127);
        send(2'd3, 0, 0, -1);
        send(2'd3, 100, 1, 5);
        wait_q("ident", 4);
        ev = '{-128, 127, -1, 5, 0, 0, 0, 0};
        check_out("ident", 4);

        // Type latched at the first element of each vector
        send(2'd0, 5, 8, 32);
        send(2'd0, 5, 8, 32);
        send(2'd1, 5, 8, 32);
        send(2'd1, 5, 8, 32);
        send(2'd1, 5, 8, 32);
        send(2'd0, 5, 8, 32);
        send(2'd0, 5, 8, 32);
        send(2'd0, 5, 8, 32);
        wait_q("latch", 8);
        ev = '{32, 32, 32, 32, 8, 8, 8, 8};
        lv = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_out("latch", 8);

        // One element so the next stream starts mid-vector (count 1)
        send(2'd3, 0, 0, 9);
        wait_q("single", 1);
        ev = '{9, 0, 0, 0, 0, 0, 0, 0};
        lv = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_out("single", 1);

        // Backpressure: six elements with output stalled for seven cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(2'd3, 0, 0, i);
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_q("bp", 6);
        ev = '{1, 2, 3, 4, 5, 6, 0, 0};
        lv = '{0, 0, 1, 0, 0, 0, 0, 0};
        check_out("bp", 6);
        chk("bp_max_occ", max_occ, 3);
        chk("bp_saw_not_ready", int'(not_ready_seen > 0), 1);
        chk("bp_stall_stable", stall_err, 0);

        // Reset with two elements in flight
        send(2'd3, 0, 0, 11);
        send(2'd3, 0, 0, 12);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_delta", int'(delta), 0);
        chk("midrst_last", int'(last), 0);
        chk("midrst_nothing_out", q.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        send(2'd3, 0, 0, 21);
        send(2'd3, 0, 0, 22);
        send(2'd3, 0, 0, 23);
        send(2'd3, 0, 0, 24);
        wait_q("post", 4);
        ev = '{21, 22, 23, 24, 0, 0, 0, 0};
        lv = '{0, 0, 0, 1, 0, 0, 0, 0};
        check_out("post", 4);
        repeat (5) @(posedge clk);
        #1;
        chk("no_extra_out", q.size(), 0);
        chk("stray_done", stray_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/activation_grad_unit.md
Name: activation_grad_unit

Overview:
Backward-pass counterpart of the forward activation stage in the FFN systolic datapath. Consumes a stream of upstream gradients g together with the matching forward activation outputs y and pre-activations z. Emits the local gradient delta = g * f'(z) per element. Fully pipelined with valid/ready handshakes, one element per cycle, and tracks vector boundaries for the weight-update controller.

Parameters:
DATA_WIDTH, 8, signed fixed-point width of z, y, g and delta.
FRAC_BITS, 4, fractional bits; ONE = 1 << FRAC_BITS.
VEC_LEN, 16, elements per gradient vector (>= 1).

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_i  input  1  asynchronous, active-high reset.
activ_type_i  input  2  0=ReLU, 1=sigmoid, 2=tanh, 3=identity; sampled only on first element of a vector.
in_valid_i  input  1  input element valid.
in_ready_o  output  1  unit can accept an element this cycle.
z_i  input  DATA_WIDTH  signed pre-activation.
y_i  input  DATA_WIDTH  signed forward activation output.
g_i  input  DATA_WIDTH  signed upstream gradient.
out_valid_o  output  1  delta valid.
out_ready_i  input  1  downstream accepts delta.
delta_o  output  DATA_WIDTH  signed local gradient.
last_o  output  1  delta_o is element VEC_LEN-1 of its vector.
done_o  output  1  one-cycle pulse when a last element handshakes on the output.

Behaviour:
- Reset (asynchronous, active-high): all stage valids 0, out_valid_o=0, delta_o=0, last_o=0, done_o=0, element counter=0, latched type=0. in_ready_o=1 after reset deasserts. Asserting reset mid-vector discards all in-flight data.
- Handshake: input accepted when in_valid_i && in_ready_o. Output transfers when out_valid_o && out_ready_i. out_valid_o, delta_o and last_o hold stable while out_ready_i=0.
- Pipeline, 3 stages (S1 derivative, S2 multiply, S3 scale/saturate/output register). A stage advances when its successor is empty or advancing. in_ready_o = !S1_valid || S1_advances; it is combinational from out_ready_i. Latency is 3 cycles from accept to out_valid_o with no backpressure. Throughput is 1 per cycle. Order is preserved and no element is lost or duplicated.
- Element counter increments on each input accept and wraps VEC_LEN-1 -> 0. The last tag is set on the element accepted at count VEC_LEN-1 and travels with that element. activ_type_i is latched when count==0 and is used for the whole vector. Each element carries its type through the pipe.
- S1 derivative d, signed 2*DATA_WIDTH:
  - ReLU: d = ONE if z>0, else 0 (z=0 gives 0).
  - Sigmoid: d = (y*(ONE-y)) >>> FRAC_BITS.
  - Tanh: d = ONE - ((y*y) >>> FRAC_BITS).
  - Identity: d = ONE.
- S2: p = g*d at full width.
- S3: delta = p >>> FRAC_BITS (arithmetic shift, truncation toward -inf). Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- done_o pulses for exactly the cycle in which a last-tagged delta transfers.
- Simultaneous accept and output in the same cycle is legal, including on the last element of one vector and the first element of the next. The new vector's type is latched independently of data in flight.

Optional Feature:
ACTIV_GRAD_SAT_CNT_EN:
- Defined: adds output port sat_cnt_o, 16 bits. It increments, holding at 0xFFFF, each time a transferred delta was saturated. It is cleared by reset and cleared on the cycle done_o pulses; a saturation in that same cycle sets it to 1.
- Undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
(DATA_WIDTH=8, FRAC_BITS=4, ONE=16, VEC_LEN=4)
- ReLU vector, out_ready_i=1: z={5,-3,0,1}, g={20,20,20,-7} -> delta={20,0,0,-7}, first at 3 cycles after accept; last_o and done_o on 4th only.
- Sigmoid: y=8, g=32 -> d=4, delta=8. Tanh: y=0, g=-40 -> delta=-40. Identity: g=-128 -> delta=-128.
- Saturation: tanh with y=-128, g=16 -> d=-1008, p>>>4=-1008 -> delta=-128. With ACTIV_GRAD_SAT_CNT_EN defined, sat_cnt_o=1.
- Backpressure: stream 6 elements with out_ready_i=0 for cycles 2..8 -> at most 3 held, in_ready_o=0 while full, all 6 emitted in order, none duplicated, delta_o stable while stalled.
- Type latching: change activ_type_i from ReLU to sigmoid at element 2 -> whole vector processed as ReLU; next vector uses the value present at its first accept.
- Reset with 2 elements in flight -> out_valid_o=0 and delta_o=0 immediately; next vector restarts at count 0 with last_o on its 4th element.
